// File: rtl/tm1638_pkg.sv
// Shared constants, state encoding and driver request payload for the TM1638 frame sequencer.
package tm1638_pkg;

  localparam int unsigned IMG_BYTES = 16;
  localparam int unsigned KEY_BYTES = 4;
  localparam int unsigned IMG_AW    = 4;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP       = 8'h80;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STB_LO  = 3'd1;
  localparam logic [2:0] ST_LATCH   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_STB_HI  = 3'd4;
  localparam logic [2:0] ST_PUBLISH = 3'd5;
  localparam logic [2:0] ST_GAP     = 3'd6;

  localparam logic [1:0] TXN_MODE  = 2'd0;
  localparam logic [1:0] TXN_IMAGE = 2'd1;
  localparam logic [1:0] TXN_DISP  = 2'd2;
  localparam logic [1:0] TXN_KEYS  = 2'd3;

  typedef struct packed {
    logic             rw;
    logic [BYTE_W-1:0] data;
  } drv_req_t;

  // Index of the final byte of a transaction (byte 0 is always the command).
  function automatic logic [4:0] txn_last_byte(input logic [1:0] txn);
    case (txn)
      TXN_IMAGE: return 5'(IMG_BYTES);
      TXN_KEYS:  return 5'(KEY_BYTES);
      default:   return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/tm1638_regfile.sv
// 16x8 display image: one synchronous write port, one asynchronous read port.
module tm1638_regfile
  import tm1638_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IMG_AW-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [IMG_AW-1:0] raddr,
  output logic [BYTE_W-1:0] rdata_c
);

  logic [BYTE_W-1:0] mem [IMG_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < IMG_BYTES; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/tm1638_ctrl.sv
// Frame sequencer: loops mode cmd, display RAM burst, display control and key scan
// through the TM1638 byte driver, publishing the 32 key bits once per frame.
module tm1638_ctrl
  import tm1638_pkg::*;
#(
  parameter int unsigned STB_GAP   = 4,
  parameter int unsigned FRAME_GAP = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        disp_on,
  input  logic [2:0]  bright,
  input  logic        seg_we,
  input  logic [3:0]  seg_addr,
  input  logic [7:0]  seg_wdata,
  output logic [31:0] keys,
  output logic        key_valid,
  output logic        frame_busy,
  output logic        stb,
  output logic        drv_latch,
  output logic        drv_rw,
  output logic [7:0]  drv_wdata,
  input  logic [7:0]  drv_rdata,
  input  logic        drv_busy
);

  localparam int unsigned CNT_MAX = (FRAME_GAP > STB_GAP) ? FRAME_GAP : STB_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [2:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       txn, txn_d;
  logic [4:0]       byte_idx, byte_d;
  logic             disp_q, disp_d;
  logic [2:0]       bright_q, bright_d;
  logic [31:0]      shadow, shadow_d;
  logic [31:0]      keys_d;
  logic             key_valid_d, frame_busy_d, stb_d, drv_latch_d;
  drv_req_t         req_q, req_d;
  logic [7:0]       img_rdata_c, tx_byte_c;
  logic [1:0]       key_idx_c;

  tm1638_regfile u_img (
    .clk     (clk),
    .rst_n   (rst),
    .we      (seg_we),
    .waddr   (seg_addr),
    .wdata   (seg_wdata),
    .raddr   (4'(byte_idx - 5'd1)),
    .rdata_c (img_rdata_c)
  );

  assign key_idx_c = 2'(byte_idx - 5'd1);
  assign drv_rw    = req_q.rw;
  assign drv_wdata = req_q.data;

  // Byte for the current transaction slot; image bytes follow the 0xC0 address command.
  always_comb begin
    tx_byte_c = 8'h00;
    case (txn)
      TXN_MODE:  tx_byte_c = CMD_WRITE_AUTO;
      TXN_IMAGE: tx_byte_c = (byte_idx == 5'd0) ? CMD_ADDR0 : img_rdata_c;
      TXN_DISP:  tx_byte_c = CMD_DISP | {4'b0000, disp_q, bright_q};
      default:   tx_byte_c = (byte_idx == 5'd0) ? CMD_READ_KEYS : 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    txn_d        = txn;
    byte_d       = byte_idx;
    disp_d       = disp_q;
    bright_d     = bright_q;
    shadow_d     = shadow;
    keys_d       = keys;
    key_valid_d  = 1'b0;
    frame_busy_d = frame_busy;
    drv_latch_d  = 1'b0;
    req_d        = req_q;
    stb_d        = !(state == ST_STB_LO || state == ST_LATCH || state == ST_WAIT);

    case (state)
      ST_IDLE: begin
        if (en) begin
          state_d      = ST_STB_LO;
          cnt_d        = '0;
          txn_d        = TXN_MODE;
          byte_d       = '0;
          disp_d       = disp_on;
          bright_d     = bright;
          frame_busy_d = 1'b1;
        end
      end
      ST_STB_LO: begin
        if (cnt == CNT_W'(STB_GAP - 1)) state_d = ST_LATCH;
        else                            cnt_d   = cnt + CNT_W'(1);
      end
      ST_LATCH: begin
        drv_latch_d = 1'b1;
        req_d.rw    = !(txn == TXN_KEYS && byte_idx != 5'd0);
        req_d.data  = tx_byte_c;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end
      // The latch cycle itself is skipped so the driver has time to raise busy.
      ST_WAIT: begin
        if (cnt == '0) begin
          cnt_d = CNT_W'(1);
        end else if (!drv_busy) begin
          if (!req_q.rw) shadow_d[{key_idx_c, 3'b000} +: 8] = drv_rdata;
          if (byte_idx == txn_last_byte(txn)) begin
            state_d = ST_STB_HI;
            cnt_d   = '0;
          end else begin
            byte_d  = byte_idx + 5'd1;
            state_d = ST_LATCH;
          end
        end
      end
      ST_STB_HI: begin
        if (cnt == CNT_W'(STB_GAP - 1)) begin
          cnt_d = '0;
          if (txn == TXN_KEYS) begin
            state_d      = ST_PUBLISH;
            keys_d       = shadow;
            key_valid_d  = 1'b1;
            frame_busy_d = 1'b0;
          end else begin
            txn_d   = txn + 2'd1;
            byte_d  = '0;
            state_d = ST_STB_LO;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_PUBLISH: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == CNT_W'(FRAME_GAP - 1)) state_d = ST_IDLE;
        else                              cnt_d   = cnt + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      txn        <= TXN_MODE;
      byte_idx   <= '0;
      disp_q     <= 1'b0;
      bright_q   <= '0;
      shadow     <= '0;
      keys       <= '0;
      key_valid  <= 1'b0;
      frame_busy <= 1'b0;
      stb        <= 1'b1;
      drv_latch  <= 1'b0;
      req_q      <= '{rw: 1'b1, data: 8'h00};
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      txn        <= txn_d;
      byte_idx   <= byte_d;
      disp_q     <= disp_d;
      bright_q   <= bright_d;
      shadow     <= shadow_d;
      keys       <= keys_d;
      key_valid  <= key_valid_d;
      frame_busy <= frame_busy_d;
      stb        <= stb_d;
      drv_latch  <= drv_latch_d;
      req_q      <= req_d;
    end
  end

endmodule

// File: tb/tb_tm1638_ctrl.sv
// Self-checking bench for tm1638_ctrl with a byte-driver model and a latch/STB monitor.
module tb_tm1638_ctrl;

  localparam int G  = 4;
  localparam int FG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, disp_on, seg_we;
  logic [2:0]  bright;
  logic [3:0]  seg_addr;
  logic [7:0]  seg_wdata;
  logic [31:0] keys;
  logic        key_valid, frame_busy, stb, drv_latch, drv_rw;
  logic [7:0]  drv_wdata, drv_rdata;
  logic        drv_busy;

  tm1638_ctrl #(.STB_GAP(G), .FRAME_GAP(FG)) dut (
    .clk(clk), .rst(rst), .en(en), .disp_on(disp_on), .bright(bright),
    .seg_we(seg_we), .seg_addr(seg_addr), .seg_wdata(seg_wdata),
    .keys(keys), .key_valid(key_valid), .frame_busy(frame_busy), .stb(stb),
    .drv_latch(drv_latch), .drv_rw(drv_rw), .drv_wdata(drv_wdata),
    .drv_rdata(drv_rdata), .drv_busy(drv_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Byte driver model: busy for 3 cycles after each latch, returns resp[] on reads.
  logic [7:0] resp [4];
  logic [1:0] rd_idx;
  logic [1:0] bcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_busy  <= 1'b0;
      bcnt      <= 2'd0;
      rd_idx    <= 2'd0;
      drv_rdata <= 8'h00;
    end else if (drv_latch) begin
      drv_busy <= 1'b1;
      bcnt     <= 2'd3;
      if (!drv_rw) begin
        drv_rdata <= resp[rd_idx];
        rd_idx    <= rd_idx + 2'd1;
      end
    end else if (bcnt != 2'd0) begin
      bcnt <= bcnt - 2'd1;
      if (bcnt == 2'd1) drv_busy <= 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0] grp;
    logic       rw;
    logic [7:0] wd;
  } lat_t;

  lat_t       log_q [$];
  int         kv_cnt;
  logic [7:0] img_model [16];

  // Monitor: logs latched bytes per STB group and checks STB framing and timing.
  initial begin
    int cyc = 0, hi_run = 100, lo_run = 0, fb_rise = 0, busy_fall = 0;
    logic [7:0] grp = 8'd0;
    logic first_lat = 1'b0, first_frame_lat = 1'b0;
    logic prev_stb = 1'b1, prev_fb = 1'b0, prev_busy = 1'b0;
    logic [31:0] prev_keys = 32'd0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        hi_run = 100; lo_run = 0; first_lat = 1'b0; first_frame_lat = 1'b0;
        prev_stb = 1'b1; prev_fb = 1'b0; prev_busy = 1'b0; prev_keys = keys;
      end else begin
        if (prev_stb && !stb) begin
          chk("stb_high_gap", 64'(hi_run >= G), 64'd1);
          grp = grp + 8'd1;
          lo_run = 0;
          first_lat = 1'b1;
        end
        if (stb) hi_run++;
        else begin lo_run++; hi_run = 0; end
        if (!prev_fb && frame_busy) begin fb_rise = cyc; first_frame_lat = 1'b1; end
        if (prev_busy && !drv_busy) busy_fall = cyc;
        if (drv_latch) begin
          log_q.push_back('{grp: grp, rw: drv_rw, wd: drv_wdata});
          chk("stb_low_at_latch", 64'(stb), 64'd0);
          if (first_lat) chk("stb_low_before_byte", 64'((lo_run - 1) >= G), 64'd1);
          if (first_frame_lat) chk("first_latch_delay", 64'(cyc - fb_rise), 64'(G + 1));
          first_lat = 1'b0;
          first_frame_lat = 1'b0;
        end
        if (key_valid) begin
          kv_cnt++;
          chk("key_valid_delay", 64'(cyc - busy_fall), 64'(G + 1));
        end
        if (keys !== prev_keys) chk("keys_only_on_valid", 64'(key_valid), 64'd1);
        prev_stb = stb; prev_fb = frame_busy; prev_busy = drv_busy; prev_keys = keys;
      end
    end
  end

  task automatic seg_write(input logic [3:0] a, input logic [7:0] d);
    seg_addr = a; seg_wdata = d; seg_we = 1'b1;
    @(negedge clk);
    seg_we = 1'b0;
    img_model[a] = d;
  endtask

  task automatic wait_log(input int n, input string name);
    int t = 0;
    while (log_q.size() < n && t < 1000) begin @(negedge clk); t++; end
    chk(name, 64'(log_q.size() >= n), 64'd1);
  endtask

  task automatic wait_kv(input string name);
    int t = 0;
    while (!key_valid && t < 2000) begin @(negedge clk); t++; end
    chk(name, 64'(key_valid), 64'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_disp);
    logic [7:0] g0, eb;
    logic erw;
    int eg;
    chk({tag, "_len"}, 64'(log_q.size()), 64'd24);
    if (log_q.size() == 24) begin
      g0 = log_q[0].grp;
      for (int i = 0; i < 24; i++) begin
        if (i == 0)       begin eg = 0; erw = 1'b1; eb = 8'h40; end
        else if (i == 1)  begin eg = 1; erw = 1'b1; eb = 8'hC0; end
        else if (i <= 17) begin eg = 1; erw = 1'b1; eb = img_model[4'(i - 2)]; end
        else if (i == 18) begin eg = 2; erw = 1'b1; eb = exp_disp; end
        else if (i == 19) begin eg = 3; erw = 1'b1; eb = 8'h42; end
        else              begin eg = 3; erw = 1'b0; eb = 8'h00; end
        chk($sformatf("%s_byte%0d", tag, i),
            64'({8'(log_q[i].grp - g0), log_q[i].rw, (erw ? log_q[i].wd : 8'h00)}),
            64'({8'(eg), erw, eb}));
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] exp_disp, input logic [31:0] exp_keys);
    int t = 0;
    log_q.delete();
    kv_cnt = 0;
    en = 1'b1;
    while (!frame_busy && t < 100) begin @(negedge clk); t++; end
    chk({tag, "_start"}, 64'(frame_busy), 64'd1);
    en = 1'b0;
    wait_kv({tag, "_kv"});
    repeat (FG + 4) @(negedge clk);
    check_frame(tag, exp_disp);
    chk({tag, "_kv_count"}, 64'(kv_cnt), 64'd1);
    chk({tag, "_keys"}, 64'(keys), 64'(exp_keys));
    chk({tag, "_idle_busy"}, 64'(frame_busy), 64'd0);
    chk({tag, "_idle_stb"}, 64'(stb), 64'd1);
  endtask

  typedef struct {
    logic       disp_on;
    logic [2:0] bright;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] r0, r1, r2, r3;
    logic [7:0] exp_disp;
    logic [31:0] exp_keys;
  } vec_t;

  initial begin
    vec_t vecs [4];
    vecs[0] = '{disp_on: 1'b1, bright: 3'd7, addr: 4'd0,  wdata: 8'h00,
                r0: 8'h11, r1: 8'h22, r2: 8'h44, r3: 8'h88, exp_disp: 8'h8F, exp_keys: 32'h88442211};
    vecs[1] = '{disp_on: 1'b1, bright: 3'd3, addr: 4'd0,  wdata: 8'h3F,
                r0: 8'h04, r1: 8'h03, r2: 8'h02, r3: 8'h01, exp_disp: 8'h8B, exp_keys: 32'h01020304};
    vecs[2] = '{disp_on: 1'b0, bright: 3'd5, addr: 4'd15, wdata: 8'hFF,
                r0: 8'hA0, r1: 8'hB1, r2: 8'hC2, r3: 8'hD3, exp_disp: 8'h85, exp_keys: 32'hD3C2B1A0};
    vecs[3] = '{disp_on: 1'b0, bright: 3'd0, addr: 4'd9,  wdata: 8'h6D,
                r0: 8'h00, r1: 8'h00, r2: 8'h00, r3: 8'h00, exp_disp: 8'h80, exp_keys: 32'h00000000};

    for (int i = 0; i < 16; i++) img_model[i] = 8'h00;
    rst = 1'b0; en = 1'b0; disp_on = 1'b0; bright = 3'd0;
    seg_we = 1'b0; seg_addr = 4'd0; seg_wdata = 8'h00;
    for (int i = 0; i < 4; i++) resp[i] = 8'h00;
    kv_cnt = 0;

    repeat (3) @(negedge clk);
    chk("rst_stb", 64'(stb), 64'd1);
    chk("rst_latch", 64'(drv_latch), 64'd0);
    chk("rst_rw", 64'(drv_rw), 64'd1);
    chk("rst_wdata", 64'(drv_wdata), 64'h00);
    chk("rst_keys", 64'(keys), 64'd0);
    chk("rst_kv", 64'(key_valid), 64'd0);
    chk("rst_busy", 64'(frame_busy), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      disp_on = vecs[v].disp_on;
      bright  = vecs[v].bright;
      resp[0] = vecs[v].r0; resp[1] = vecs[v].r1; resp[2] = vecs[v].r2; resp[3] = vecs[v].r3;
      seg_write(vecs[v].addr, vecs[v].wdata);
      run_frame($sformatf("vec%0d", v), vecs[v].exp_disp, vecs[v].exp_keys);
    end

    // en dropped during the image burst: frame completes, nothing follows.
    log_q.delete();
    kv_cnt = 0;
    en = 1'b1;
    wait_log(4, "en_drop_reach_t2");
    en = 1'b0;
    wait_kv("en_drop_kv");
    repeat (FG + 40) @(negedge clk);
    chk("en_drop_total_bytes", 64'(log_q.size()), 64'd24);
    chk("en_drop_stb_high", 64'(stb), 64'd1);
    chk("en_drop_kv_count", 64'(kv_cnt), 64'd1);

    // Write to address 7 in the very cycle its byte is taken from the image.
    seg_write(4'd7, 8'h5A);
    log_q.delete();
    en = 1'b1;
    wait_log(9, "same_cycle_reach_addr6");
    en = 1'b0;
    repeat (4) @(negedge clk);
    seg_addr = 4'd7; seg_wdata = 8'hA5; seg_we = 1'b1;
    @(negedge clk);
    seg_we = 1'b0;
    chk("same_cycle_latch_follows", 64'(drv_latch), 64'd1);
    wait_kv("same_cycle_kv");
    repeat (FG + 4) @(negedge clk);
    chk("same_cycle_old_value", 64'((log_q.size() > 9) ? log_q[9].wd : 8'hXX), 64'h5A);
    img_model[7] = 8'hA5;
    run_frame("next_frame_new_value", 8'h80, 32'h00000000);

    // Reset asserted mid-burst, away from any clock edge.
    log_q.delete();
    en = 1'b1;
    wait_log(7, "reset_reach_t2_byte5");
    chk("reset_stb_low_before", 64'(stb), 64'd0);
    #2 rst = 1'b0;
    #1 chk("reset_stb_async_high", 64'(stb), 64'd1);
    chk("reset_keys_cleared", 64'(keys), 64'd0);
    en = 1'b0;
    for (int i = 0; i < 16; i++) img_model[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    disp_on = 1'b1; bright = 3'd2;
    resp[0] = 8'h0F; resp[1] = 8'hF0; resp[2] = 8'h3C; resp[3] = 8'hC3;
    run_frame("post_reset", 8'h8A, 32'hC33CF00F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm1638_ctrl.md
# tm1638_ctrl

Frame sequencer that owns the TM1638 byte driver (`tm1638`) and keeps the panel refreshed without host involvement. It holds a 16-byte display image written by the host, then loops continuously through four transactions, each framed by STB: write-mode command, display RAM burst, display-control command, and key scan. After every key scan it publishes the 32 key-scan bits. It sits between the application logic and the byte driver; the byte driver's `data` inout is resolved at the top level from this block's `drv_wdata`/`drv_rdata`.

## Interface
- `STB_GAP`, 4: minimum clk cycles STB is held low before the first byte and high between transactions (≥1).
- `FRAME_GAP`, 1024: idle clk cycles between the end of one frame and the start of the next (≥1).
- `clk` in 1: system clock; the block's only clock.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: when high, frames run back-to-back; when low, the current frame completes and the block idles.
- `disp_on` in 1: display enable, sampled at frame start.
- `bright` in 3: brightness level, sampled at frame start.
- `seg_we` in 1: display-image write strobe.
- `seg_addr` in 4: display-image byte address (even = digit segments, odd = LED).
- `seg_wdata` in 8: display-image write data.
- `keys` out 32: last key scan; byte k occupies bits [8k+7:8k].
- `key_valid` out 1: one-cycle pulse when `keys` updates.
- `frame_busy` out 1: high from frame start to the `key_valid` pulse.
- `stb` out 1: TM1638 STB pin, active low.
- `drv_latch` out 1: one-cycle start pulse to the byte driver.
- `drv_rw` out 1: 1 = write byte, 0 = read byte.
- `drv_wdata` out 8: byte to send.
- `drv_rdata` in 8: byte returned by the driver on a read.
- `drv_busy` in 1: driver busy.

## Operation
- Frame sequence (24 bytes in total):
  - T1: 0x40 (write, auto-increment).
  - T2: 0xC0, then image[0..15].
  - T3: 0x80 | (disp_on<<3) | bright.
  - T4: 0x42, then 4 reads with `drv_rw`=0.
- Each transaction follows the same steps: STB_LO (drive `stb`=0, wait STB_GAP cycles) → per byte LATCH → WAIT → repeat or STB_HI (drive `stb`=1, wait STB_GAP cycles).
- After T4 STB_HI, the block goes to PUBLISH, then GAP (wait FRAME_GAP cycles), then IDLE.
- States: IDLE, STB_LO, LATCH, WAIT, STB_HI, PUBLISH, GAP. A transaction index (0–3) and a byte index (0–16) select the command or data byte.
- LATCH: `drv_latch`=1 for exactly one cycle, with `drv_rw`/`drv_wdata` valid in that cycle and held stable until WAIT exits.
- WAIT: the first cycle after LATCH is ignored; the block then waits for `drv_busy`=0. On reads, `drv_rdata` is captured in the cycle `drv_busy` is first observed low.
- Read bytes go into a shadow register. PUBLISH copies the shadow to `keys` and pulses `key_valid`, so `keys` is never partially updated.
- IDLE → STB_LO when `en`=1; `disp_on`/`bright` are captured on that transition.
- Image writes are accepted every cycle, including mid-frame. A byte is read from the image in its LATCH cycle. If `seg_we` targets the same address in that same cycle, the old value is sent and the new one appears next frame.
- `en` dropping mid-frame has no effect until GAP ends.

## Timing
- Reset values: `stb`=1, `drv_latch`=0, `drv_rw`=1, `drv_wdata`=0x00, `keys`=0, `key_valid`=0, `frame_busy`=0, image = all 0x00, state = IDLE.
- Reset asserted mid-frame forces `stb` high asynchronously and abandons the transaction. The first frame after reset release starts with T1.
- First LATCH occurs STB_GAP+1 cycles after the IDLE exit.
- Frame length = 4·(2·STB_GAP) + 24·(2 + driver busy time) + FRAME_GAP + small constant. Exact count is checked against the driver model.
- `key_valid` follows the final read's `drv_busy` fall by STB_GAP+1 cycles.

## Structure
- `tm1638_pkg`:
  - Command constants: CMD_WRITE_AUTO 8'h40, CMD_READ_KEYS 8'h42, CMD_ADDR0 8'hC0, CMD_DISP 8'h80.
  - Byte counts: 16 image bytes, 4 key bytes.
  - State encoding.
- Sub-module `tm1638_regfile`: 16×8 register file with one synchronous write port and one asynchronous read port, reset to zero.

## Test plan
- Reset, `en`=1, image all zero, `bright`=7, `disp_on`=1 → bytes 40 | C0 00×16 | 8F | 42 then 4 reads, each group bracketed by `stb` low, with ≥STB_GAP cycles of `stb` high between groups.
- Write addr 0 = 0x3F, addr 15 = 0xFF, then run one frame → T2 carries 0x3F first and 0xFF last.
- Driver model returns 0x11, 0x22, 0x44, 0x88 → `keys`=0x88442211, with exactly one `key_valid` pulse and `keys` unchanged until that pulse.
- Drop `en` during T2 → frame completes, `stb` stays high, no further LATCH.
- Assert reset during T2 byte 5 → `stb` goes to 1 without waiting for a clock edge. After release, the next frame starts with 0x40.
- Same-cycle `seg_we` to the byte being latched → old value sent this frame, new value sent next frame.
